// File: rtl/jtframe_romrq_2way.sv
// jtframe_romrq_2way: CPU ROM responder backed by a two-entry 16-bit word cache over one SDRAM slot.
//   clk, rstn         : clock, asynchronous active-low reset
//   clr               : synchronous cache invalidate
//   addr, addr_ok     : CPU byte address and request strobe
//   dout, data_ok     : selected byte and its valid flag (zero latency on hit)
//   sdram_addr/req    : word address and request of the pending fetch
//   sdram_ack/dst/din : request accepted, data strobe, fetched word
module jtframe_romrq_2way #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    output logic [7:0]    dout,
    output logic          data_ok,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_din
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t             state_q, state_d;
    logic [1:0]         valid_q, valid_d;
    logic [1:0][AW-2:0] tag_q, tag_d;
    logic [1:0][15:0]   data_q, data_d;
    logic               victim_q, victim_d;
    logic               discard_q, discard_d;
    logic               req_q, req_d;
    logic [AW-2:0]      saddr_q, saddr_d;
    logic [1:0]         hit;
    logic [15:0]        sel;
    logic               fill;

    // Entry 0 takes priority on a double hit and also supplies the don't-care byte on a miss.
    always_comb begin
        hit[0]  = valid_q[0] & (tag_q[0] == addr[AW-1:1]);
        hit[1]  = valid_q[1] & (tag_q[1] == addr[AW-1:1]);
        sel     = (!hit[0] && hit[1]) ? data_q[1] : data_q[0];
        dout    = addr[0] ? sel[15:8] : sel[7:0];
        data_ok = addr_ok & (|hit) & ~clr;
    end

    assign sdram_req  = req_q;
    assign sdram_addr = saddr_q;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        victim_d  = victim_q;
        discard_d = discard_q;
        req_d     = req_q;
        saddr_d   = saddr_q;
        fill      = 1'b0;
        // A hit on entry k makes the other entry the next victim; hit[0] encodes ~k directly.
        if (data_ok) victim_d = hit[0];
        case (state_q)
            IDLE: begin
                if (addr_ok && hit == 2'b00 && !clr) begin
                    saddr_d = addr[AW-1:1];
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = WAIT_DATA;
                    fill    = sdram_dst;
                end
            end
            WAIT_DATA: fill = sdram_dst;
            default: state_d = IDLE;
        endcase
        if (fill) begin
            data_d[victim_q]  = sdram_din;
            tag_d[victim_q]   = saddr_q;
            valid_d[victim_q] = ~discard_q;
            victim_d          = ~victim_q;
            discard_d         = 1'b0;
            state_d           = IDLE;
        end
        // Invalidate overrides any fill this cycle; a fetch still in flight is marked for discard.
        if (clr) begin
            valid_d   = 2'b00;
            discard_d = state_d != IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            victim_q  <= 1'b0;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            saddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            victim_q  <= victim_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            saddr_q   <= saddr_d;
        end
    end
endmodule

// File: doc/jtframe_romrq_2way.md
# jtframe_romrq_2way

Responder side of the CPU ROM handshake. It receives a byte address plus `addr_ok` (the CPU's `rom_cs`) and answers with `dout` plus `data_ok` (the CPU's `rom_ok`). Misses are served from 16-bit SDRAM words through a two-entry word cache. It sits between a 6809 system wrapper's ROM port and one SDRAM bank slot. Cache hits answer in the same cycle, so the CPU clock-enable gate never stalls on repeated fetches from a word.

## Interface
Parameters:
- `AW`, 15, CPU-side byte address width; SDRAM word address is `AW-1` bits.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rstn` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous cache invalidate, e.g. during ROM download.
- `addr` in AW: CPU byte address.
- `addr_ok` in 1: CPU requests data at `addr`.
- `dout` out 8: byte selected by `addr[0]` from the matching entry.
- `data_ok` out 1: `dout` is valid for the current `addr`.
- `sdram_addr` out AW-1: word address of the pending fetch.
- `sdram_req` out 1: fetch request, held until acknowledged.
- `sdram_ack` in 1: request accepted (one-cycle pulse).
- `sdram_dst` in 1: `sdram_din` valid this cycle (one-cycle pulse).
- `sdram_din` in 16: fetched word.

## Operation
Storage:
- Two entries, k=0 and k=1. Each entry holds `valid[k]`, `tag[k]` (AW-1 bits) and `data[k]` (16 bits).
- A `victim` bit selects the entry to be replaced next.

Hit logic (combinational):
- `hit[k] = valid[k] & tag[k]==addr[AW-1:1]`.
- `data_ok = addr_ok & (hit[0]|hit[1]) & !clr`.
- `dout`:
  - `addr[0]`=0 selects byte [7:0] of the hit entry; `addr[0]`=1 selects byte [15:8].
  - If both entries hit, entry 0 wins.
  - If neither entry hits, `dout` is entry 0's selected byte (don't-care, but deterministic).
- On a registered hit of entry k, `victim <= ~k`.

State machine:
- IDLE:
  - If `addr_ok & !hit & !clr`: latch `sdram_addr <= addr[AW-1:1]`, set `sdram_req <= 1`, go to WAIT_ACK.
- WAIT_ACK:
  - `sdram_req` stays 1.
  - On `sdram_ack`: `sdram_req <= 0`, go to WAIT_DATA.
  - If `sdram_dst` arrives in the same cycle as `sdram_ack`, handle it as in WAIT_DATA in that same cycle.
- WAIT_DATA:
  - On `sdram_dst`: write `data[victim] <= sdram_din`, `tag[victim] <= sdram_addr`, `valid[victim] <= !discard`. Then `victim <= ~victim`, clear `discard`, go to IDLE.

Boundary rules:
- `addr` changing or `addr_ok` dropping mid-fetch: the fetch completes and fills the cache. The new address is evaluated in IDLE afterwards.
- `clr` in any state clears both `valid` bits. If a fetch is outstanding, `clr` sets `discard` so the returning word is not marked valid. `clr` coincident with `sdram_dst`: clr wins, and the entry ends invalid.
- No new request is issued in a cycle where `clr`=1.
- Spurious `sdram_ack` or `sdram_dst` in IDLE is ignored.
- Reset (asynchronous, any state) forces:
  - state IDLE;
  - `sdram_req`=0, `sdram_addr`=0;
  - `valid`=00, `tag`=0, `data`=0;
  - `victim`=0, `discard`=0.
  - Resulting outputs: `data_ok`=0 and `dout`=0x00.
  - The SDRAM controller must tolerate the abandoned request.

## Timing
- Hit: `data_ok` goes high in the same cycle as `addr_ok`; zero latency.
- Miss, with `addr_ok` first sampled at edge 0:
  - `sdram_req`=1 from after edge 0.
  - `sdram_ack` at edge A drops `sdram_req` after A.
  - `sdram_dst` at edge D (D ≥ A) writes the entry at D.
  - `data_ok`=1 in the cycle after D, as long as `addr` still matches.
- Minimum miss latency with ack and dst at edge 1: `data_ok` is high in cycle 2.
- `sdram_addr` is stable from the request until the fill.
- Exactly one request is outstanding at a time.

## Test plan
- Reset then idle: `addr_ok`=0 gives `data_ok`=0, `sdram_req`=0, `dout`=0x00. Asserting `rstn`=0 mid WAIT_DATA gives `sdram_req`=0 immediately.
- Cold miss: `addr`=0x1235, ack after 3 cycles, dst 2 cycles later with `sdram_din`=0xBEEF.
  - `sdram_addr`=0x091A.
  - `data_ok` rises the cycle after dst with `dout`=0xBE.
  - Changing to `addr`=0x1234 gives `dout`=0xEF with no new request.
- Two-way replacement: fill words 0x0100, then 0x0200, then hit 0x0100, then miss 0x0300.
  - 0x0300 replaces the 0x0200 entry.
  - A hit on 0x0100 still needs no request; 0x0200 triggers a request.
- Address change mid-fetch: miss on 0x0040, change `addr` to 0x0041 (same word) before dst.
  - One request only.
  - Then change to 0x0800: a second request is issued only after the first fill.
- `clr` during WAIT_DATA, then dst with 0x1234: the entry stays invalid, `data_ok` stays 0, and the same address re-requests. `clr` coincident with dst gives the same result.
- ack and dst in the same cycle: the fill happens and `data_ok` is high the next cycle. Stray dst in IDLE causes no state change.
